// File: rtl/ntt_pointwise_mult.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ntt_pointwise_mult: pairs two forward-NTT packets A,B and emits           |
// | C[i] = A[i]*B[i] mod Q as one iNTT-tagged packet. Macro: PW_NINV_SCALE_EN |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ntt_pointwise_mult #(
  parameter int W         = 32,
  parameter int N         = 8,
  parameter int Modulus_Q = 241,
  parameter int N_INV     = 211
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           data_valid_in,
  input  logic           mode_in,
  input  logic [N*W-1:0] Data_in,
  output logic [N*W-1:0] Data_out,
  output logic           data_valid_out,
  output logic           iNTT_mode_out,
  output logic           pair_pending
);

  localparam logic [0:0]     S_IDLE   = 1'b0;
  localparam logic [0:0]     S_HOLD_A = 1'b1;
  localparam logic [2*W-1:0] c_Q      = (2*W)'(Modulus_Q);

  logic [0:0]     r_state;
  logic [W-1:0]   r_a  [N];
  logic [2*W-1:0] r_s1 [N];
  logic           r_v1;
  logic [W-1:0]   r_s2 [N];
  logic           r_v2;
  logic           w_accept;

  // iNTT-tagged packets on the shared bus are not operands
  assign w_accept     = data_valid_in && !mode_in;
  assign pair_pending = (r_state == S_HOLD_A);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_v1    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_a[i]  <= '0;
        r_s1[i] <= '0;
      end
    end else begin
      r_v1 <= 1'b0;
      if (w_accept) begin
        if (r_state == S_IDLE) begin
          r_state <= S_HOLD_A;
          for (int i = 0; i < N; i++) begin
            r_a[i] <= Data_in[i*W +: W];
          end
        end else begin
          r_state <= S_IDLE;
          r_v1    <= 1'b1;
          for (int i = 0; i < N; i++) begin
            r_s1[i] <= (2*W)'(r_a[i]) * (2*W)'(Data_in[i*W +: W]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v2 <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_s2[i] <= '0;
      end
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        for (int i = 0; i < N; i++) begin
          r_s2[i] <= W'(r_s1[i] % c_Q);
        end
      end
    end
  end

`ifdef PW_NINV_SCALE_EN
  localparam logic [2*W-1:0] c_NINV = (2*W)'(N_INV);

  logic [W-1:0] r_s3 [N];
  logic         r_v3;

  // Folds the inverse-transform 1/N scaling in ahead of the iNTT
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v3 <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_s3[i] <= '0;
      end
    end else begin
      r_v3 <= r_v2;
      if (r_v2) begin
        for (int i = 0; i < N; i++) begin
          r_s3[i] <= W'(((2*W)'(r_s2[i]) * c_NINV) % c_Q);
        end
      end
    end
  end

  always_comb begin
    Data_out = '0;
    for (int i = 0; i < N; i++) begin
      Data_out[i*W +: W] = r_s3[i];
    end
  end

  assign data_valid_out = r_v3;
  assign iNTT_mode_out  = r_v3;
`else
  always_comb begin
    Data_out = '0;
    for (int i = 0; i < N; i++) begin
      Data_out[i*W +: W] = r_s2[i];
    end
  end

  assign data_valid_out = r_v2;
  assign iNTT_mode_out  = r_v2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_pointwise_mult.sv
`default_nettype none
// Scoreboard bench for ntt_pointwise_mult: directed pairs, queued expectations,
// an independent monitor checking data, mode tag and latency of every pulse.
module tb_ntt_pointwise_mult;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int DW = N * W;
`ifdef PW_NINV_SCALE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          data_valid_in;
  logic          mode_in;
  logic [DW-1:0] Data_in;
  logic [DW-1:0] Data_out;
  logic          data_valid_out;
  logic          iNTT_mode_out;
  logic          pair_pending;

  ntt_pointwise_mult #(.W(W), .N(N), .Modulus_Q(241), .N_INV(211)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_valid_in  (data_valid_in),
    .mode_in        (mode_in),
    .Data_in        (Data_in),
    .Data_out       (Data_out),
    .data_valid_out (data_valid_out),
    .iNTT_mode_out  (iNTT_mode_out),
    .pair_pending   (pair_pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] last_exp = '0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [DW-1:0] fill(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [DW-1:0] pk8(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
    return {W'(a7), W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  // Drive for the next edge; returns #1 after the current edge
  task automatic drive(input logic v, input logic m, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    data_valid_in = v;
    mode_in       = m;
    Data_in       = d;
  endtask

  task automatic expect_result(input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc + LAT;
    sb.push_back(e);
    last_exp = d;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (data_valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("result_data", Data_out, e.data);
        chk("result_mode", DW'(iNTT_mode_out), DW'(1));
        chk("result_latency", DW'(cyc), DW'(e.due));
      end
    end
  end

  logic [DW-1:0] e1, e2, e3, e4, e5, e6, e7;

  initial begin
`ifdef PW_NINV_SCALE_EN
    e1 = pk8(181, 121, 61, 1, 182, 122, 62, 2);
    e2 = fill(211);
    e3 = pk8(0, 91, 0, 143, 0, 91, 150, 183);
    e4 = fill(151);
    e5 = fill(155);
    e6 = fill(143);
    e7 = fill(123);
`else
    e1 = pk8(2, 4, 6, 8, 10, 12, 14, 16);
    e2 = fill(1);
    e3 = pk8(0, 5, 0, 180, 0, 5, 236, 18);
    e4 = fill(3);
    e5 = fill(35);
    e6 = fill(180);
    e7 = fill(20);
`endif
    reset = 1'b1; data_valid_in = 1'b0; mode_in = 1'b0; Data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data_out", Data_out, '0);
    chk("reset_valid", DW'(data_valid_out), '0);
    chk("reset_mode", DW'(iNTT_mode_out), '0);
    chk("reset_pending", DW'(pair_pending), '0);
    reset = 1'b0;

    // Distinct lanes, small products
    drive(1'b1, 1'b0, pk8(1, 2, 3, 4, 5, 6, 7, 8));
    drive(1'b1, 1'b0, fill(2));
    chk("pending_after_a", DW'(pair_pending), DW'(1));
    expect_result(e1);
    drive(1'b0, 1'b0, '0);
    chk("pending_after_b", DW'(pair_pending), '0);
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("hold_data_out", Data_out, last_exp);
    chk("hold_valid_low", DW'(data_valid_out), '0);

    // Q-1 squared wraps to 1
    drive(1'b1, 1'b0, fill(240));
    drive(1'b1, 1'b0, fill(240));
    expect_result(e2);
    drive(1'b0, 1'b0, '0);
    repeat (LAT + 1) @(posedge clk);

    // Operands at or above Q
    drive(1'b1, 1'b0, pk8(241, 242, 482, 1000, 0, 1, 240, 100));
    drive(1'b1, 1'b0, fill(5));
    expect_result(e3);
    drive(1'b0, 1'b0, '0);
    repeat (LAT + 1) @(posedge clk);

    // Back-to-back pairs on four consecutive cycles
    drive(1'b1, 1'b0, fill(1));
    drive(1'b1, 1'b0, fill(3));
    expect_result(e4);
    drive(1'b1, 1'b0, fill(5));
    drive(1'b1, 1'b0, fill(7));
    expect_result(e5);
    drive(1'b0, 1'b0, '0);
    repeat (LAT + 2) @(posedge clk);

    // iNTT-tagged packet between A and B is ignored
    drive(1'b1, 1'b0, fill(100));
    drive(1'b1, 1'b1, fill(77));
    drive(1'b1, 1'b0, fill(50));
    chk("pending_across_mode1", DW'(pair_pending), DW'(1));
    expect_result(e6);
    drive(1'b0, 1'b0, '0);
    repeat (LAT + 1) @(posedge clk);

    // Reset while holding A discards it
    drive(1'b1, 1'b0, fill(9));
    @(posedge clk);
    #1;
    data_valid_in = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("pending_after_reset", DW'(pair_pending), '0);
    data_valid_in = 1'b1;
    Data_in = fill(4);
    drive(1'b1, 1'b0, fill(5));
    chk("pending_b_as_a", DW'(pair_pending), DW'(1));
    expect_result(e7);
    drive(1'b0, 1'b0, '0);
    repeat (LAT + 2) @(posedge clk);

    // Reset on the edge after B kills the in-flight product
    drive(1'b1, 1'b0, fill(1));
    drive(1'b1, 1'b0, fill(3));
    @(posedge clk);
    #1;
    data_valid_in = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("kill_data_out", Data_out, '0);
    chk("kill_valid", DW'(data_valid_out), '0);
    chk("kill_mode", DW'(iNTT_mode_out), '0);
    chk("kill_pending", DW'(pair_pending), '0);

    chk("missing_pulses", DW'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
